// File: rtl/tpu_fp_pkg.sv
// Shared bfloat16 constants and packing helper for the accumulator drain path.
package tpu_fp_pkg;

    localparam int          BF16_BIAS       = 127;
    localparam int          BF16_EXP_MAX    = 255;
    localparam logic [14:0] BF16_INF_MAG    = 15'h7F80;
    localparam int          DEFAULT_EXP_OFF = 24;

    function automatic logic [15:0] bf16_pack(input logic       sign,
                                              input logic [7:0] exp,
                                              input logic [6:0] man);
        return {sign, exp, man};
    endfunction

endpackage

// File: rtl/acc_to_bf16_pipe_if.sv
// Beat-level handshake bundle between accumulator drain, converter and writeback.
interface acc_to_bf16_pipe_if #(
    parameter int ACC_W = 20,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ACC_W-1:0]   in_acc;
    logic [7:0]               in_exp_off;
    logic                     in_rne;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*16-1:0]      out_bf16;

    modport master (
        output in_valid, in_acc, in_exp_off, in_rne, out_ready,
        input  in_ready, out_valid, out_bf16
    );

    modport slave (
        input  in_valid, in_acc, in_exp_off, in_rne, out_ready,
        output in_ready, out_valid, out_bf16
    );
endinterface

// File: rtl/lead_one_det.sv
// Leading-one position and all-zero flag for a W-bit unsigned value.
module lead_one_det #(
    parameter int W    = 20,
    parameter int LZ_W = $clog2(W)
) (
    input  logic [W-1:0]    a,
    output logic [LZ_W-1:0] pos,
    output logic            zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) pos = LZ_W'(i);
        end
    end

    assign zero = ~|a;

endmodule

// File: rtl/acc_to_bf16_pipe.sv
// Two-stage, multi-lane signed accumulator to bfloat16 converter with valid/ready.
// S1 captures sign/magnitude/leading-one per lane; S2 rounds, range-checks and packs.
module acc_to_bf16_pipe
    import tpu_fp_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LANES = 4,
    parameter int LZ_W  = $clog2(ACC_W)
) (
    input  logic             clk,
    input  logic             rst,
    acc_to_bf16_pipe_if.slave bus
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(BF16_EXP_MAX);

    logic       s1_valid_reg;
    logic       s2_valid_reg;
    logic [7:0] exp_off_reg;
    logic       rne_reg;
    logic       adv1;
    logic       adv2;
    logic       accept;

    // A stage may load when it is empty or the stage after it is draining.
    assign adv2          = !s2_valid_reg | bus.out_ready;
    assign adv1          = !s1_valid_reg | adv2;
    assign accept        = bus.in_valid & adv1;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            exp_off_reg  <= '0;
            rne_reg      <= 1'b0;
        end else begin
            if (adv1) s1_valid_reg <= bus.in_valid;
            if (adv2) s2_valid_reg <= s1_valid_reg;
            if (accept) begin
                exp_off_reg <= bus.in_exp_off;
                rne_reg     <= bus.in_rne;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0]  acc;
            logic [ACC_W-1:0]  mag;
            logic [LZ_W-1:0]   pos;
            logic              zero;

            // Leading one is implied by pos_reg, so only the bits below the top are kept.
            logic              sign_reg;
            logic [ACC_W-2:0]  mag_reg;
            logic              zero_reg;
            logic [LZ_W-1:0]   pos_reg;
            logic [15:0]       bf16_reg;

            logic [LZ_W-1:0]   shift_amt;
            logic [ACC_W+7:0]  norm;
            logic [6:0]        man;
            logic              rbit;
            logic              sticky;
            logic              inc;
            logic [7:0]        man_sum;
            logic [6:0]        man_r;
            logic signed [9:0] exp_v;
            logic signed [9:0] exp_r;
            logic [15:0]       bf16_next;

            assign acc = bus.in_acc[gi*ACC_W +: ACC_W];
            // Two's-complement negate maps the most negative value to 2^(ACC_W-1) exactly.
            assign mag = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;

            lead_one_det #(.W(ACC_W), .LZ_W(LZ_W)) u_lod (
                .a    (mag),
                .pos  (pos),
                .zero (zero)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sign_reg <= 1'b0;
                    mag_reg  <= '0;
                    zero_reg <= 1'b0;
                    pos_reg  <= '0;
                end else if (accept) begin
                    sign_reg <= acc[ACC_W-1];
                    mag_reg  <= mag[ACC_W-2:0];
                    zero_reg <= zero;
                    pos_reg  <= pos;
                end
            end

            always_comb begin
                shift_amt = LZ_W'(ACC_W - 1) - pos_reg;
                // Left-justify so the bit just below the leading one lands at the top.
                norm      = {mag_reg, 9'b0} << shift_amt;
                man       = norm[ACC_W+7 -: 7];
                rbit      = norm[ACC_W];
                sticky    = |norm[ACC_W-1:0];
                inc       = rne_reg & rbit & (sticky | man[0]);
                man_sum   = {1'b0, man} + {7'b0, inc};
                man_r     = man_sum[7] ? 7'd0 : man_sum[6:0];
                exp_v     = 10'(pos_reg) + 10'(BF16_BIAS) - {{2{exp_off_reg[7]}}, exp_off_reg};
                exp_r     = man_sum[7] ? (exp_v + 10'sd1) : exp_v;
                bf16_next = bf16_pack(sign_reg, exp_r[7:0], man_r);
                if (zero_reg)
                    bf16_next = 16'h0000;
                else if (exp_r >= EXP_MAX_S)
                    bf16_next = {sign_reg, BF16_INF_MAG};
                else if (exp_r <= 10'sd0)
                    bf16_next = {sign_reg, 15'b0};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    bf16_reg <= '0;
                else if (adv2 && s1_valid_reg)
                    bf16_reg <= bf16_next;
            end

            assign bus.out_bf16[gi*16 +: 16] = bf16_reg;
        end
    endgenerate

endmodule

// File: tb/tb_acc_to_bf16_pipe.sv
// Scoreboard bench: driver pushes expected beats on accept, monitor pops on output.
module tb_acc_to_bf16_pipe;
    import tpu_fp_pkg::*;

    localparam int ACC_W = 20;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_to_bf16_pipe_if #(.ACC_W(ACC_W), .LANES(LANES)) bus();

    acc_to_bf16_pipe #(.ACC_W(ACC_W), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] exp;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;  // 0 low, 1 high, 2 pseudo-random

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [79:0] rep_acc(input logic [19:0] a);
        return {4{a}};
    endfunction

    function automatic logic [63:0] rep16(input logic [15:0] v);
        return {4{v}};
    endfunction

    initial begin : rdy_drv
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rdy_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
            else               bus.out_ready = (rdy_mode == 1);
        end
    end

    initial begin : monitor
        bit          held;
        logic [63:0] held_val;
        exp_t        e;
        held = 0;
        held_val = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                held = 0;
            end else begin
                if (held) begin
                    n_tests++;
                    if (bus.out_valid !== 1'b1 || bus.out_bf16 !== held_val) begin
                        n_fail++;
                        $display("FAIL stall_hold: got valid=%b data=%h required valid=1 data=%h",
                                 bus.out_valid, bus.out_bf16, held_val);
                    end
                end
                held = 0;
                if (bus.out_valid && bus.out_ready) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h required no beat", bus.out_bf16);
                    end else begin
                        e = sb.pop_front();
                        if (bus.out_bf16 !== e.exp) begin
                            n_fail++;
                            $display("FAIL beat_data: got %h required %h", bus.out_bf16, e.exp);
                        end else begin
                            $display("[TB] beat out=%h expected=%h ok", bus.out_bf16, e.exp);
                        end
                        if (e.lat) begin
                            n_tests++;
                            if (cyc - e.cyc != 2) begin
                                n_fail++;
                                $display("FAIL latency: got %0d cycles required 2", cyc - e.cyc);
                            end
                        end
                    end
                end else if (bus.out_valid) begin
                    held     = 1;
                    held_val = bus.out_bf16;
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [79:0] acc, input logic [7:0] off, input bit rne,
                        input logic [63:0] exp, input bit lat);
        bit   done;
        exp_t e;
        done           = 0;
        bus.in_acc     = acc;
        bus.in_exp_off = off;
        bus.in_rne     = rne;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            #4;
            if (bus.in_ready) begin
                e.exp = exp;
                e.cyc = cyc;
                e.lat = lat;
                sb.push_back(e);
                done = 1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles required 1");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #4;
            if (sb.size() == 0 && !bus.out_valid) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending required 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end else begin
            $display("[TB] %s got=%h ok", name, got);
        end
    endtask

    typedef struct {
        logic [19:0] acc;
        bit          rne;
        logic [15:0] exp;
    } vec_t;

    vec_t vtab[8];
    logic [7:0] def_off;

    initial begin : stim
        def_off = 8'(DEFAULT_EXP_OFF);
        vtab[0] = '{20'h00001, 1'b1, 16'h3380};
        vtab[1] = '{20'hFFFFF, 1'b1, 16'hB380};
        vtab[2] = '{20'h00000, 1'b1, 16'h0000};
        vtab[3] = '{20'h80000, 1'b1, 16'hBD00};
        vtab[4] = '{20'h001FF, 1'b1, 16'h3800};
        vtab[5] = '{20'h001FF, 1'b0, 16'h37FF};
        vtab[6] = '{20'h00101, 1'b1, 16'h3780};
        vtab[7] = '{20'h00103, 1'b1, 16'h3782};

        bus.in_valid   = 1'b0;
        bus.in_acc     = '0;
        bus.in_exp_off = def_off;
        bus.in_rne     = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check1("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check1("reset_out_bf16", bus.out_bf16, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values and rounding, back-to-back with out_ready high.
        rdy_mode = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            send(rep_acc(vtab[i].acc), def_off, vtab[i].rne, rep16(vtab[i].exp), 1'b1);
        drain();

        // Lane independence.
        send({20'h00000, 20'h001FF, 20'hFFFFF, 20'h00001}, def_off, 1'b1,
             {16'h0000, 16'h3800, 16'hB380, 16'h3380}, 1'b1);
        // Range limits.
        send(rep_acc(20'h40000), 8'h92, 1'b1, rep16(16'h7F80), 1'b1);
        send(rep_acc(20'hC0000), 8'h92, 1'b1, rep16(16'hFF80), 1'b1);
        send(rep_acc(20'h00001), 8'h7F, 1'b1, rep16(16'h0000), 1'b1);
        send(rep_acc(20'hFFFFF), 8'h7F, 1'b1, rep16(16'h8000), 1'b1);
        drain();

        // Both stages full with out_ready low must block input.
        rdy_mode = 0;
        send(rep_acc(20'h00002), def_off, 1'b1, rep16(16'h3400), 1'b0);
        send(rep_acc(20'h00001), def_off, 1'b1, rep16(16'h3380), 1'b0);
        #1;
        check1("full_in_ready", 64'(bus.in_ready), 64'd0);
        rdy_mode = 1;
        drain();

        // Backpressure stream.
        rdy_mode = 2;
        for (int i = 0; i < 8; i++)
            send(rep_acc(vtab[7 - i].acc), def_off, vtab[7 - i].rne, rep16(vtab[7 - i].exp), 1'b0);
        rdy_mode = 1;
        drain();

        // Asynchronous reset with two beats in flight.
        rdy_mode = 0;
        send(rep_acc(20'h001FF), def_off, 1'b1, rep16(16'h3800), 1'b0);
        send(rep_acc(20'h80000), def_off, 1'b1, rep16(16'hBD00), 1'b0);
        #1;
        check1("prereset_out_valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check1("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        check1("midreset_out_bf16", bus.out_bf16, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        send(rep_acc(20'h00001), def_off, 1'b1, rep16(16'h3380), 1'b1);
        drain();
        repeat (4) @(negedge clk);

        check1("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
